bram_portb_arbiter: RTL

- Shares the data BRAM's port B between NUM_REQ peripheral requesters: display scan-out, paddle/controller input and score logic.
- Port A stays dedicated to CPU instruction fetch and register load.
- Round-robin arbitration, at most one access per cycle, optional short bus lock for multi-word transfers.
- Sits between the peripherals and the bram instance's data_b/addr_b/we_b/q_b pins.

---
 rtl/bram_portb_arbiter_pkg.sv | 21 ++
 rtl/bram_portb_arbiter_rr_priority_pick.sv | 35 +++
 rtl/bram_portb_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bram_portb_arbiter_pkg.sv
// rtl/bram_portb_arbiter_pkg.sv - shared state encoding, requester ids and index-width helper
package bram_portb_arbiter_pkg;

  // Arbiter FSM: plain round-robin or a requester holding the bus
  typedef enum logic {
    ST_RR     = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Requester slots in the default four-port build
  localparam int REQ_DISPLAY = 0;
  localparam int REQ_INPUT   = 1;
  localparam int REQ_SCORE   = 2;
  localparam int REQ_SPARE   = 3;

  // Bits needed to hold a requester index (at least one)
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_portb_arbiter_rr_priority_pick.sv
// rtl/bram_portb_arbiter_rr_priority_pick.sv - combinational round-robin pick starting after last
module bram_portb_arbiter_rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic [NUM_REQ-1:0] excl_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] mask;

  // Walk from the farthest slot to the nearest so the first requester after last wins
  always_comb begin
    int p;
    p        = 0;
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    mask     = req_i & ~excl_i;
    for (int k = NUM_REQ; k >= 1; k--) begin
      p = (int'(last_i) + k) % NUM_REQ;
      if (mask[p]) begin
        valid_o     = 1'b1;
        idx_o       = IDX_W'(p);
        onehot_o    = '0;
        onehot_o[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_portb_arbiter.sv
// rtl/bram_portb_arbiter.sv - round-robin BRAM port B arbiter with bus lock; BRAM_ARB_STATS_EN adds wait counters
module bram_portb_arbiter
  import bram_portb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [ADDR_W-1:0]         addr_b_o,
  output logic [DATA_W-1:0]         data_b_o,
  output logic                      we_b_o,
  input  logic [DATA_W-1:0]         q_b_i
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic                      stats_clr_i,
  output logic [NUM_REQ*16-1:0]     wait_cnt_o
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] ack_q, rvalid_q;
  logic [ADDR_W-1:0]  addr_b_q;
  logic [DATA_W-1:0]  data_b_q;
  logic               we_b_q;
  logic               rd_pend_q;
  logic [IDX_W-1:0]   rd_idx_q;

  logic [NUM_REQ-1:0] owner_oh, rd_oh, gnt_oh, pick_excl, pick_oh;
  logic [IDX_W-1:0]   pick_last, pick_idx, gnt_idx;
  logic               owner_hold, others_pending, pick_valid, gnt;

  // Owner still wants the bus, and whether anyone else is waiting behind it
  always_comb begin
    owner_oh           = '0;
    owner_oh[owner_q]  = 1'b1;
    rd_oh              = '0;
    rd_oh[rd_idx_q]    = 1'b1;
    owner_hold         = (state_q == ST_LOCKED) && req_i[owner_q] && lock_i[owner_q];
    others_pending     = |(req_i & ~owner_oh);
  end

  // Round-robin search base and exclusion: an expired owner sits out one arbitration
  always_comb begin
    pick_last = last_q;
    pick_excl = '0;
    if (state_q == ST_LOCKED) begin
      pick_last = owner_q;
      if (owner_hold) pick_excl = owner_oh;
    end
  end

  bram_portb_arbiter_rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req_i),
    .last_i   (pick_last),
    .excl_i   (pick_excl),
    .valid_o  (pick_valid),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  // Grant decision and next FSM state
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    gnt        = 1'b0;
    gnt_idx    = '0;
    gnt_oh     = '0;
    if (owner_hold && ((lock_cnt_q < CNT_W'(MAX_LOCK)) || !others_pending)) begin
      gnt     = 1'b1;
      gnt_idx = owner_q;
      gnt_oh  = owner_oh;
      last_d  = owner_q;
      if (lock_cnt_q < CNT_W'(MAX_LOCK)) lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end else begin
      state_d    = ST_RR;
      lock_cnt_d = '0;
      if (pick_valid) begin
        gnt     = 1'b1;
        gnt_idx = pick_idx;
        gnt_oh  = pick_oh;
        last_d  = pick_idx;
        if (lock_i[pick_idx]) begin
          state_d    = ST_LOCKED;
          owner_d    = pick_idx;
          lock_cnt_d = CNT_W'(1);
        end
      end
    end
  end

  // FSM state, BRAM port B drive and read-return tag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_RR;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      lock_cnt_q <= '0;
      ack_q      <= '0;
      rvalid_q   <= '0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
      we_b_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      ack_q      <= gnt_oh;
      we_b_q     <= gnt && we_i[gnt_idx];
      if (gnt) begin
        addr_b_q <= addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
        data_b_q <= wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
      end
      rd_pend_q  <= gnt && !we_i[gnt_idx];
      rd_idx_q   <= gnt_idx;
      rvalid_q   <= rd_pend_q ? rd_oh : '0;
    end
  end

  assign ack_o    = ack_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = q_b_i;
  assign addr_b_o = addr_b_q;
  assign data_b_o = data_b_q;
  assign we_b_o   = we_b_q;

`ifdef BRAM_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] wait_cnt_q;

  // Saturating per-requester count of cycles spent requesting without an ack
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr_i) begin
          wait_cnt_q[i*16 +: 16] <= 16'h0000;
        end else if (req_i[i] && !ack_q[i] && (wait_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
          wait_cnt_q[i*16 +: 16] <= wait_cnt_q[i*16 +: 16] + 16'h0001;
        end
      end
    end
  end

  assign wait_cnt_o = wait_cnt_q;
`endif

endmodule
